// File: rtl/rtc_seq_ctrl_if.sv
`timescale 1ns/1ps
// rtc_seq_ctrl_if
//   Handshake bundle between the RTC sequencer and the blocks around it.
//   master : drives keys / sub_done and observes the sequencer outputs (bench, top level)
//   slave  : the sequencer itself
//   key        [N_EDIT]  debounced edit keys, level, active-high
//   sub_done              completion pulse from the active sub-FSM
//   state_o    [3]        current state (0 INIT, 1 READ, 2 WAIT, 3 EDIT, 4 WRITE)
//   do_init/do_read/do_write  sub-FSM enables
//   bus_sel    [2]        RTC bus owner (0 init, 1 read, 2 write, 3 none)
//   edit_mux              data mux selects edit counters
//   en_edit    [N_EDIT]   one-hot edit-counter enable
//   wr_sel     [N_EDIT]   one-hot write-back channel select
//   edit_abort            one-cycle pulse on edit timeout
//   busy                  high in INIT, READ, WRITE
interface rtc_seq_ctrl_if #(
  parameter int N_EDIT = 3
);
  logic [N_EDIT-1:0] key;
  logic              sub_done;
  logic [2:0]        state_o;
  logic              do_init;
  logic              do_read;
  logic              do_write;
  logic [1:0]        bus_sel;
  logic              edit_mux;
  logic [N_EDIT-1:0] en_edit;
  logic [N_EDIT-1:0] wr_sel;
  logic              edit_abort;
  logic              busy;

  modport master (
    output key, sub_done,
    input  state_o, do_init, do_read, do_write, bus_sel, edit_mux,
           en_edit, wr_sel, edit_abort, busy
  );

  modport slave (
    input  key, sub_done,
    output state_o, do_init, do_read, do_write, bus_sel, edit_mux,
           en_edit, wr_sel, edit_abort, busy
  );
endinterface

// File: rtl/rtc_seq_ctrl.sv
`timescale 1ns/1ps
// rtc_seq_ctrl
//   Top-level sequencer of the RTC controller. Runs one INIT pass, then
//   alternates READ and WAIT (refresh). A held edit key in WAIT enters EDIT
//   for the lowest-index pressed channel; releasing that key writes the
//   channel back (WRITE). An optional EDIT timeout aborts the edit, and the
//   keys are then ignored until all of them have been released once.
// Ports
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    rtc_seq_ctrl_if.slave (keys, sub_done in; enables, selects, status out)
module rtc_seq_ctrl #(
  parameter int N_EDIT         = 3,
  parameter int INIT_CYCLES    = 560,
  parameter int READ_CYCLES    = 431,
  parameter int REFRESH_CYCLES = 1599569,
  parameter int WRITE_CYCLES   = 259,
  parameter int EDIT_TIMEOUT   = 0,
  parameter int CNT_W          = 21
) (
  input  logic           clk,
  input  logic           reset,
  rtc_seq_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EDIT  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  // Largest count the phase counter must reach; the counter holds values
  // up to MAX_LEN-1, so MAX_LEN must not exceed 2**CNT_W.
  localparam int MAX_IR   = (INIT_CYCLES > READ_CYCLES) ? INIT_CYCLES : READ_CYCLES;
  localparam int MAX_RW   = (REFRESH_CYCLES > WRITE_CYCLES) ? REFRESH_CYCLES : WRITE_CYCLES;
  localparam int MAX_IRW  = (MAX_IR > MAX_RW) ? MAX_IR : MAX_RW;
  localparam int MAX_LEN  = (MAX_IRW > EDIT_TIMEOUT) ? MAX_IRW : EDIT_TIMEOUT;

  generate
    if (longint'(MAX_LEN) > (longint'(1) << CNT_W)) begin : g_cnt_w_check
      $error("rtc_seq_ctrl: CNT_W too narrow for the configured phase lengths");
    end
  endgenerate

  localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST   = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EDIT_LAST    = CNT_W'((EDIT_TIMEOUT > 0) ? EDIT_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [N_EDIT-1:0] sel, sel_nxt;
  logic              armed, armed_nxt;

  logic [N_EDIT-1:0] key;
  logic              sub_done;
  logic              any_key, key_held, abort;
  logic [N_EDIT-1:0] key_low1;

  assign key      = bus.key;
  assign sub_done = bus.sub_done;
  assign any_key  = |key;
  // Two's-complement trick isolates the lowest set key bit.
  assign key_low1 = key & (~key + N_EDIT'(1));
  // Only the captured channel's key matters while editing.
  assign key_held = |(key & sel);
  assign abort    = (state == ST_EDIT) && (EDIT_TIMEOUT != 0) &&
                    (cnt == EDIT_LAST) && key_held;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      ST_INIT:  if (sub_done || cnt == INIT_LAST) state_nxt = ST_READ;
      ST_READ:  if (sub_done || cnt == READ_LAST) state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A key press outranks refresh expiry in the same cycle.
        if (armed && any_key) begin
          sel_nxt   = key_low1;
          state_nxt = ST_EDIT;
        end else if (cnt == REFRESH_LAST) begin
          state_nxt = ST_READ;
        end
      end
      ST_EDIT: begin
        // Release outranks a coincident timeout.
        if (!key_held) begin
          state_nxt = ST_WRITE;
        end else if (abort) begin
          state_nxt = ST_READ;
          sel_nxt   = '0;
        end
      end
      ST_WRITE: begin
        if (sub_done || cnt == WRITE_LAST) begin
          state_nxt = ST_READ;
          sel_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        sel_nxt   = '0;
      end
    endcase
    // After an abort the keys stay locked out until all are released.
    armed_nxt = armed;
    if (abort)         armed_nxt = 1'b0;
    else if (!any_key) armed_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
      cnt   <= '0;
      sel   <= '0;
      armed <= 1'b1;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      armed <= armed_nxt;
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
  end

  // Output decode; illegal encodings look like INIT until they recover.
  logic              do_init, do_read, do_write, edit_mux;
  logic [1:0]        bus_sel;
  logic [N_EDIT-1:0] en_edit, wr_sel;
  logic [2:0]        state_o;

  always_comb begin
    do_init  = 1'b0;
    do_read  = 1'b0;
    do_write = 1'b0;
    edit_mux = 1'b0;
    bus_sel  = 2'd3;
    en_edit  = '0;
    wr_sel   = '0;
    state_o  = state;
    case (state)
      ST_READ: begin
        do_read = 1'b1;
        bus_sel = 2'd1;
      end
      ST_WAIT: ;
      ST_EDIT: begin
        edit_mux = 1'b1;
        en_edit  = sel;
      end
      ST_WRITE: begin
        do_write = 1'b1;
        bus_sel  = 2'd2;
        wr_sel   = sel;
      end
      default: begin
        do_init = 1'b1;
        bus_sel = 2'd0;
        state_o = ST_INIT;
      end
    endcase
  end

  assign bus.state_o    = state_o;
  assign bus.do_init    = do_init;
  assign bus.do_read    = do_read;
  assign bus.do_write   = do_write;
  assign bus.bus_sel    = bus_sel;
  assign bus.edit_mux   = edit_mux;
  assign bus.en_edit    = en_edit;
  assign bus.wr_sel     = wr_sel;
  assign bus.edit_abort = abort;
  assign bus.busy       = do_init | do_read | do_write;

endmodule

// File: tb/tb_rtc_seq_ctrl.sv
`timescale 1ns/1ps
module tb_rtc_seq_ctrl;
  localparam int N    = 3;
  localparam int P_IN = 8;
  localparam int P_RD = 6;
  localparam int P_RF = 20;
  localparam int P_WR = 5;
  localparam int P_TO = 30;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_seq_ctrl_if #(.N_EDIT(N)) bus ();

  rtc_seq_ctrl #(
    .N_EDIT(N), .INIT_CYCLES(P_IN), .READ_CYCLES(P_RD), .REFRESH_CYCLES(P_RF),
    .WRITE_CYCLES(P_WR), .EDIT_TIMEOUT(P_TO), .CNT_W(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: phase name, cycles spent in it, captured channel.
  int m_ph, m_el, m_ch;
  bit m_armed;

  task automatic m_reset();
    m_ph = 0; m_el = 0; m_ch = -1; m_armed = 1;
  endtask

  function automatic bit m_timeout(input logic [2:0] k);
    return (m_ph == 3) && (P_TO != 0) && (m_el == P_TO - 1) && (m_ch >= 0) && k[m_ch];
  endfunction

  // {state, do_init, do_read, do_write, bus_sel, edit_mux, en_edit, wr_sel, abort, busy}
  function automatic logic [16:0] model_out(input logic [2:0] k);
    logic [2:0] oh;
    logic [16:0] r;
    oh = (m_ch >= 0) ? 3'(1 << m_ch) : 3'b000;
    case (m_ph)
      0: r = {3'd0, 3'b100, 2'd0, 1'b0, 3'b0, 3'b0, 1'b0, 1'b1};
      1: r = {3'd1, 3'b010, 2'd1, 1'b0, 3'b0, 3'b0, 1'b0, 1'b1};
      2: r = {3'd2, 3'b000, 2'd3, 1'b0, 3'b0, 3'b0, 1'b0, 1'b0};
      3: r = {3'd3, 3'b000, 2'd3, 1'b1, oh,   3'b0, m_timeout(k), 1'b0};
      default: r = {3'd4, 3'b001, 2'd2, 1'b0, 3'b0, oh, 1'b0, 1'b1};
    endcase
    return r;
  endfunction

  task automatic model_step(input logic [2:0] k, input logic sd);
    int nxt;
    nxt = m_ph;
    case (m_ph)
      0: if (sd || m_el == P_IN - 1) nxt = 1;
      1: if (sd || m_el == P_RD - 1) nxt = 2;
      2: begin
        if (m_armed && k != 0) begin
          for (int i = N - 1; i >= 0; i--) if (k[i]) m_ch = i;
          nxt = 3;
        end else if (m_el == P_RF - 1) nxt = 1;
      end
      3: begin
        if (!k[m_ch]) nxt = 4;
        else if (m_timeout(k)) begin nxt = 1; m_armed = 0; m_ch = -1; end
      end
      default: if (sd || m_el == P_WR - 1) begin nxt = 1; m_ch = -1; end
    endcase
    if (k == 0) m_armed = 1;
    if (nxt != m_ph) begin m_ph = nxt; m_el = 0; end
    else m_el++;
  endtask

  logic [2:0] s_state;
  logic       s_abort, s_write;

  function automatic logic [16:0] dut_out();
    return {bus.state_o, bus.do_init, bus.do_read, bus.do_write, bus.bus_sel,
            bus.edit_mux, bus.en_edit, bus.wr_sel, bus.edit_abort, bus.busy};
  endfunction

  // One clock: drive at negedge, compare against the model, clock, advance model.
  task automatic cycle(input logic [2:0] k, input logic sd);
    @(negedge clk);
    bus.key = k; bus.sub_done = sd;
    #1;
    chk("model", int'(dut_out()), int'(model_out(k)));
    s_state = bus.state_o; s_abort = bus.edit_abort; s_write = bus.do_write;
    @(posedge clk);
    model_step(k, sd);
  endtask

  typedef struct {
    logic [2:0] key; logic sd; int n;
    int st; int bsel; int en; int wr; int busy; int emux;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_abort, ab_idx, n_wr, n_edit, rd_len, guard;
    logic [2:0] k;
    logic sd;

    tbl[0] = '{3'b000, 1'b0, 8,  1, 1, 0, 0, 1, 0};
    tbl[1] = '{3'b000, 1'b0, 6,  2, 3, 0, 0, 0, 0};
    tbl[2] = '{3'b000, 1'b0, 20, 1, 1, 0, 0, 1, 0};
    tbl[3] = '{3'b000, 1'b0, 6,  2, 3, 0, 0, 0, 0};
    tbl[4] = '{3'b110, 1'b0, 1,  3, 3, 2, 0, 0, 1};
    tbl[5] = '{3'b110, 1'b0, 9,  3, 3, 2, 0, 0, 1};
    tbl[6] = '{3'b100, 1'b0, 1,  4, 2, 0, 2, 1, 0};
    tbl[7] = '{3'b000, 1'b0, 5,  1, 1, 0, 0, 1, 0};
    tbl[8] = '{3'b000, 1'b0, 6,  2, 3, 0, 0, 0, 0};

    bus.key = '0; bus.sub_done = 1'b0; reset = 1'b0;
    m_reset();
    #2;
    chk("reset_state", int'(bus.state_o), 0);
    chk("reset_do_init", int'(bus.do_init), 1);
    chk("reset_bus_sel", int'(bus.bus_sel), 0);
    chk("reset_outputs", int'(dut_out()), int'(model_out(3'b000)));
    #16 reset = 1'b1;  // t=18: between edges

    // Table-driven walk: boot, refresh, edit of channel 1 with key 2 held.
    for (int i = 0; i < 9; i++) begin
      repeat (tbl[i].n) cycle(tbl[i].key, tbl[i].sd);
      #1;
      chk($sformatf("row%0d_state", i), int'(bus.state_o), tbl[i].st);
      chk($sformatf("row%0d_bus_sel", i), int'(bus.bus_sel), tbl[i].bsel);
      chk($sformatf("row%0d_en_edit", i), int'(bus.en_edit), tbl[i].en);
      chk($sformatf("row%0d_wr_sel", i), int'(bus.wr_sel), tbl[i].wr);
      chk($sformatf("row%0d_busy", i), int'(bus.busy), tbl[i].busy);
      chk($sformatf("row%0d_edit_mux", i), int'(bus.edit_mux), tbl[i].emux);
    end

    // key[0] held: timeout abort at EDIT cnt 29, then keys locked out.
    n_abort = 0; ab_idx = -1; n_wr = 0; n_edit = 0;
    for (int i = 0; i < 70; i++) begin
      cycle(3'b001, 1'b0);
      if (s_abort) begin n_abort++; ab_idx = i; end
      if (s_write) n_wr++;
      if (i > 30 && s_state == 3'd3) n_edit++;
    end
    chk("abort_count", n_abort, 1);
    chk("abort_cycle", ab_idx, 30);
    chk("abort_no_write", n_wr, 0);
    chk("abort_no_reentry", n_edit, 0);

    // Release once, press again: EDIT is reachable again.
    cycle(3'b000, 1'b0);
    guard = 0;
    while (m_ph != 3 && guard < 40) begin cycle(3'b001, 1'b0); guard++; end
    #1 chk("rearm_edit", int'(bus.state_o), 3);
    cycle(3'b000, 1'b0);
    #1 chk("rearm_write", int'(bus.state_o), 4);

    // sub_done at READ cnt 2 ends READ after 3 cycles.
    guard = 0;
    while (!(m_ph == 1 && m_el == 0) && guard < 60) begin cycle(3'b000, 1'b0); guard++; end
    rd_len = 0;
    cycle(3'b000, 1'b0); if (s_state == 3'd1) rd_len++;
    cycle(3'b000, 1'b0); if (s_state == 3'd1) rd_len++;
    cycle(3'b000, 1'b1); if (s_state == 3'd1) rd_len++;
    #1 chk("subdone_wait", int'(bus.state_o), 2);
    chk("subdone_read_len", rd_len, 3);
    cycle(3'b000, 1'b1);
    #1 chk("subdone_ignored_wait", int'(bus.state_o), 2);

    // Key rise coincides with refresh expiry: EDIT wins.
    guard = 0;
    while (!(m_ph == 2 && m_el == 0) && guard < 60) begin cycle(3'b000, 1'b0); guard++; end
    repeat (19) cycle(3'b000, 1'b0);
    cycle(3'b100, 1'b0);
    #1 chk("collide_state", int'(bus.state_o), 3);
    chk("collide_en_edit", int'(bus.en_edit), 4);

    // Reset during WRITE cnt 2 aborts immediately.
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    #1 chk("pre_reset_write", int'(bus.state_o), 4);
    reset = 1'b0;
    #1;
    chk("midrst_state", int'(bus.state_o), 0);
    chk("midrst_do_write", int'(bus.do_write), 0);
    chk("midrst_wr_sel", int'(bus.wr_sel), 0);
    chk("midrst_do_init", int'(bus.do_init), 1);
    m_reset();
    #1 reset = 1'b1;
    repeat (8) cycle(3'b000, 1'b0);
    #1 chk("reinit_read", int'(bus.state_o), 1);

    // Random keys and sub_done against the model.
    k = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) k = 3'($urandom_range(0, 7));
      sd = ($urandom_range(0, 7) == 0);
      cycle(k, sd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
